// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue signals between rename stage, CDB, ALU and the ALU reservation station.
// The master side is the environment (rename/CDB/ALU); the slave side is the reservation station.
interface alu_reservation_station_if #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 3,
  parameter int ROB     = 2,
  parameter int ALU     = 2
);
  logic [ALU:0]     ALURequests;
  logic [WIDTH:0]   value1;
  logic [WIDTH:0]   value2;
  logic             ready1;
  logic             ready2;
  logic [ROB:0]     srcRob1;
  logic [ROB:0]     srcRob2;
  logic [ROB:0]     instrRob;
  logic [A_WIDTH:0] aluCntrl;
  logic             cdbValid;
  logic [ROB:0]     cdbRob;
  logic [WIDTH:0]   cdbValue;
  logic             flush;
  logic [ALU:0]     ALUBusyVector;
  logic             issueValid;
  logic             issueReady;
  logic [WIDTH:0]   issueValue1;
  logic [WIDTH:0]   issueValue2;
  logic [A_WIDTH:0] issueCntrl;
  logic [ROB:0]     issueRob;

  modport master (
    output ALURequests, value1, value2, ready1, ready2, srcRob1, srcRob2,
           instrRob, aluCntrl, cdbValid, cdbRob, cdbValue, flush, issueReady,
    input  ALUBusyVector, issueValid, issueValue1, issueValue2, issueCntrl, issueRob
  );

  modport slave (
    input  ALURequests, value1, value2, ready1, ready2, srcRob1, srcRob2,
           instrRob, aluCntrl, cdbValid, cdbRob, cdbValue, flush, issueReady,
    output ALUBusyVector, issueValid, issueValue1, issueValue2, issueCntrl, issueRob
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: ALU+1 entries, CDB wakeup, oldest-ready select; RS_WAKEUP_BYPASS_EN adds same-cycle CDB bypass.
// Latency: ready-at-dispatch issues one edge after dispatch; backpressure: issue register holds while issueReady is low.
module alu_reservation_station #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 3,
  parameter int ROB     = 2,
  parameter int ALU     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_reservation_station_if.slave rs_if
);

  localparam int N = ALU + 1;

  typedef struct packed {
    logic [WIDTH:0]   v1;
    logic [WIDTH:0]   v2;
    logic             r1;
    logic             r2;
    logic [ROB:0]     t1;
    logic [ROB:0]     t2;
    logic [A_WIDTH:0] cntrl;
    logic [ROB:0]     rob;
  } entry_t;

  typedef struct packed {
    logic [WIDTH:0]   v1;
    logic [WIDTH:0]   v2;
    logic [A_WIDTH:0] cntrl;
    logic [ROB:0]     rob;
  } iss_t;

  logic [N-1:0]          valid_q, valid_d;
  entry_t                ent_q [N];
  entry_t                ent_d [N];
  // age_q[i][j] set means entry i is older than entry j
  logic [N-1:0][N-1:0]   age_q, age_d;
  logic                  iss_vld_q, iss_vld_d;
  iss_t                  iss_q, iss_d;

  logic [N-1:0]          disp_oh;
  logic                  disp_found;
  logic [N-1:0]          match1, match2;
  logic [N-1:0]          elig;
  logic [N-1:0]          sel_oh;
  logic                  move;
  iss_t                  sel_dat;
  entry_t                new_ent;
  logic                  cap1, cap2;

  always_comb begin
    disp_oh    = '0;
    disp_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rs_if.ALURequests[i] && !disp_found) begin
        disp_oh[i] = 1'b1;
        disp_found = 1'b1;
      end
    end
  end

  always_comb begin
    match1 = '0;
    match2 = '0;
    elig   = '0;
    for (int i = 0; i < N; i++) begin
      match1[i] = rs_if.cdbValid && !ent_q[i].r1 && (ent_q[i].t1 == rs_if.cdbRob);
      match2[i] = rs_if.cdbValid && !ent_q[i].r2 && (ent_q[i].t2 == rs_if.cdbRob);
`ifdef RS_WAKEUP_BYPASS_EN
      elig[i] = valid_q[i] && (ent_q[i].r1 || match1[i]) && (ent_q[i].r2 || match2[i]);
`else
      elig[i] = valid_q[i] && ent_q[i].r1 && ent_q[i].r2;
`endif
    end
  end

  // An eligible entry is selected only if it is older than every other eligible entry.
  always_comb begin
    sel_oh  = '0;
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh[i] = elig[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && elig[j] && !age_q[i][j]) begin
          sel_oh[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) begin
`ifdef RS_WAKEUP_BYPASS_EN
        sel_dat.v1 = ent_q[i].r1 ? ent_q[i].v1 : rs_if.cdbValue;
        sel_dat.v2 = ent_q[i].r2 ? ent_q[i].v2 : rs_if.cdbValue;
`else
        sel_dat.v1 = ent_q[i].v1;
        sel_dat.v2 = ent_q[i].v2;
`endif
        sel_dat.cntrl = ent_q[i].cntrl;
        sel_dat.rob   = ent_q[i].rob;
      end
    end
    move = (|sel_oh) && (!iss_vld_q || rs_if.issueReady);
  end

  always_comb begin
    cap1          = !rs_if.ready1 && rs_if.cdbValid && (rs_if.cdbRob == rs_if.srcRob1);
    cap2          = !rs_if.ready2 && rs_if.cdbValid && (rs_if.cdbRob == rs_if.srcRob2);
    new_ent       = '0;
    new_ent.v1    = rs_if.ready1 ? rs_if.value1 : rs_if.cdbValue;
    new_ent.v2    = rs_if.ready2 ? rs_if.value2 : rs_if.cdbValue;
    new_ent.r1    = rs_if.ready1 || cap1;
    new_ent.r2    = rs_if.ready2 || cap2;
    new_ent.t1    = rs_if.srcRob1;
    new_ent.t2    = rs_if.srcRob2;
    new_ent.cntrl = rs_if.aluCntrl;
    new_ent.rob   = rs_if.instrRob;
  end

  always_comb begin
    valid_d   = valid_q;
    age_d     = age_q;
    iss_vld_d = iss_vld_q;
    iss_d     = iss_q;
    for (int i = 0; i < N; i++) begin
      ent_d[i] = ent_q[i];
    end

    for (int i = 0; i < N; i++) begin
      if (valid_q[i] && match1[i]) begin
        ent_d[i].r1 = 1'b1;
        ent_d[i].v1 = rs_if.cdbValue;
      end
      if (valid_q[i] && match2[i]) begin
        ent_d[i].r2 = 1'b1;
        ent_d[i].v2 = rs_if.cdbValue;
      end
    end

    if (move) begin
      iss_vld_d = 1'b1;
      iss_d     = sel_dat;
      valid_d   = valid_q & ~sel_oh;
    end else if (rs_if.issueReady) begin
      iss_vld_d = 1'b0;
    end

    // A busy target keeps its contents; the entry frees only after its move is visible.
    for (int i = 0; i < N; i++) begin
      if (disp_oh[i] && !valid_q[i]) begin
        valid_d[i] = 1'b1;
        ent_d[i]   = new_ent;
        for (int j = 0; j < N; j++) begin
          age_d[i][j] = 1'b0;
          age_d[j][i] = (j != i) && valid_q[j];
        end
      end
    end

    if (rs_if.flush) begin
      valid_d   = '0;
      age_d     = '0;
      iss_vld_d = 1'b0;
      iss_d     = iss_q;
      for (int i = 0; i < N; i++) begin
        ent_d[i] = ent_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      age_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      age_q     <= age_d;
      iss_vld_q <= iss_vld_d;
      iss_q     <= iss_d;
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign rs_if.ALUBusyVector = valid_q;
  assign rs_if.issueValid    = iss_vld_q;
  assign rs_if.issueValue1   = iss_q.v1;
  assign rs_if.issueValue2   = iss_q.v2;
  assign rs_if.issueCntrl    = iss_q.cntrl;
  assign rs_if.issueRob      = iss_q.rob;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch, wakeup, age order, stall, flush, busy-entry dispatch.
module tb_alu_reservation_station;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_reservation_station_if rs_if ();

  alu_reservation_station dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs_if (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_if.ALURequests = '0;
    rs_if.value1      = '0;
    rs_if.value2      = '0;
    rs_if.ready1      = 1'b0;
    rs_if.ready2      = 1'b0;
    rs_if.srcRob1     = '0;
    rs_if.srcRob2     = '0;
    rs_if.instrRob    = '0;
    rs_if.aluCntrl    = '0;
    rs_if.cdbValid    = 1'b0;
    rs_if.cdbRob      = '0;
    rs_if.cdbValue    = '0;
    rs_if.flush       = 1'b0;
  endtask

  task automatic set_disp(input logic [2:0] req, input logic [31:0] a, input logic ra,
                          input logic [2:0] ta, input logic [31:0] b, input logic rb,
                          input logic [2:0] tb2, input logic [2:0] rob, input logic [3:0] cn);
    rs_if.ALURequests = req;
    rs_if.value1      = a;
    rs_if.ready1      = ra;
    rs_if.srcRob1     = ta;
    rs_if.value2      = b;
    rs_if.ready2      = rb;
    rs_if.srcRob2     = tb2;
    rs_if.instrRob    = rob;
    rs_if.aluCntrl    = cn;
  endtask

  task automatic test_reset();
    clear_inputs();
    rs_if.issueReady = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (rs_if.ALUBusyVector !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", rs_if.ALUBusyVector); end
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rs_if.issueValid); end
    checks++; if (rs_if.issueValue1 !== 32'h0 || rs_if.issueValue2 !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h/%0h expected 0/0", rs_if.issueValue1, rs_if.issueValue2); end
    checks++; if (rs_if.issueRob !== 3'd0 || rs_if.issueCntrl !== 4'd0) begin errors++; $display("FAIL reset_tag: got rob %0d cntrl %0d expected 0/0", rs_if.issueRob, rs_if.issueCntrl); end
    rst_n = 1'b1;
    step();
    checks++; if (rs_if.ALUBusyVector !== 3'b000) begin errors++; $display("FAIL post_reset_busy: got %b expected 000", rs_if.ALUBusyVector); end
  endtask

  task automatic test_basic_issue();
    rs_if.issueReady = 1'b1;
    set_disp(3'b001, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 3'd3, 4'd2);
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b001) begin errors++; $display("FAIL basic_busy: got %b expected 001", rs_if.ALUBusyVector); end
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", rs_if.issueValid); end
    step();
    checks++; if (rs_if.issueValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rs_if.issueValid); end
    checks++; if (rs_if.issueValue1 !== 32'd5 || rs_if.issueValue2 !== 32'd7) begin errors++; $display("FAIL basic_values: got %0d/%0d expected 5/7", rs_if.issueValue1, rs_if.issueValue2); end
    checks++; if (rs_if.issueRob !== 3'd3 || rs_if.issueCntrl !== 4'd2) begin errors++; $display("FAIL basic_tag: got rob %0d cntrl %0d expected 3/2", rs_if.issueRob, rs_if.issueCntrl); end
    checks++; if (rs_if.ALUBusyVector !== 3'b000) begin errors++; $display("FAIL basic_busy_clear: got %b expected 000", rs_if.ALUBusyVector); end
    step();
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", rs_if.issueValid); end
  endtask

  task automatic test_wakeup();
    rs_if.issueReady = 1'b1;
    set_disp(3'b010, 32'd11, 1'b1, 3'd0, 32'd0, 1'b0, 3'd4, 3'd1, 4'd5);
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b010) begin errors++; $display("FAIL wake_busy: got %b expected 010", rs_if.ALUBusyVector); end
    rs_if.cdbValid = 1'b1;
    rs_if.cdbRob   = 3'd5;
    rs_if.cdbValue = 32'h1234;
    step();
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag: got %b expected 0", rs_if.issueValid); end
    rs_if.cdbRob   = 3'd4;
    rs_if.cdbValue = 32'hDEAD;
    step();
    clear_inputs();
`ifdef RS_WAKEUP_BYPASS_EN
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueValue2 !== 32'hDEAD) begin errors++; $display("FAIL wake_bypass: got vld %b v2 %0h expected 1/dead", rs_if.issueValid, rs_if.issueValue2); end
    checks++; if (rs_if.issueValue1 !== 32'd11 || rs_if.issueRob !== 3'd1) begin errors++; $display("FAIL wake_bypass_v1: got %0d rob %0d expected 11/1", rs_if.issueValue1, rs_if.issueRob); end
    step();
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL wake_drain: got %b expected 0", rs_if.issueValid); end
`else
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL wake_one_edge: got %b expected 0", rs_if.issueValid); end
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueValue2 !== 32'hDEAD) begin errors++; $display("FAIL wake_issue: got vld %b v2 %0h expected 1/dead", rs_if.issueValid, rs_if.issueValue2); end
    checks++; if (rs_if.issueValue1 !== 32'd11 || rs_if.issueRob !== 3'd1) begin errors++; $display("FAIL wake_v1: got %0d rob %0d expected 11/1", rs_if.issueValue1, rs_if.issueRob); end
    step();
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL wake_drain: got %b expected 0", rs_if.issueValid); end
`endif
  endtask

  task automatic test_age_order();
    logic [2:0] exp_rob [3];
    exp_rob[0] = 3'd2; exp_rob[1] = 3'd0; exp_rob[2] = 3'd1;
    rs_if.issueReady = 1'b0;
    set_disp(3'b100, 32'd20, 1'b1, 3'd0, 32'd21, 1'b1, 3'd0, 3'd2, 4'd1);
    step();
    set_disp(3'b001, 32'd0, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd0, 4'd3);
    step();
    set_disp(3'b010, 32'd10, 1'b1, 3'd0, 32'd11, 1'b1, 3'd0, 3'd1, 4'd4);
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b011) begin errors++; $display("FAIL order_busy: got %b expected 011", rs_if.ALUBusyVector); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd2 || rs_if.issueValue1 !== 32'd20) begin errors++; $display("FAIL order_stall: cycle %0d got vld %b rob %0d v1 %0d expected 1/2/20", c, rs_if.issueValid, rs_if.issueRob, rs_if.issueValue1); end
      step();
    end
    rs_if.issueReady = 1'b1;
    for (int k = 1; k < 3; k++) begin
      step();
      checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== exp_rob[k]) begin errors++; $display("FAIL order_issue: slot %0d got vld %b rob %0d expected 1/%0d", k, rs_if.issueValid, rs_if.issueRob, exp_rob[k]); end
    end
    step();
    checks++; if (rs_if.issueValid !== 1'b0 || rs_if.ALUBusyVector !== 3'b000) begin errors++; $display("FAIL order_drain: got vld %b busy %b expected 0/000", rs_if.issueValid, rs_if.ALUBusyVector); end
  endtask

  task automatic test_dispatch_capture();
    rs_if.issueReady = 1'b1;
    set_disp(3'b001, 32'd0, 1'b0, 3'd6, 32'd3, 1'b1, 3'd0, 3'd5, 4'd6);
    rs_if.cdbValid = 1'b1;
    rs_if.cdbRob   = 3'd6;
    rs_if.cdbValue = 32'd9;
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b001) begin errors++; $display("FAIL cap_busy: got %b expected 001", rs_if.ALUBusyVector); end
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueValue1 !== 32'd9 || rs_if.issueValue2 !== 32'd3) begin errors++; $display("FAIL cap_issue: got vld %b v1 %0d v2 %0d expected 1/9/3", rs_if.issueValid, rs_if.issueValue1, rs_if.issueValue2); end
    step();
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL cap_drain: got %b expected 0", rs_if.issueValid); end
  endtask

  task automatic test_busy_dispatch();
    rs_if.issueReady = 1'b0;
    set_disp(3'b010, 32'd60, 1'b1, 3'd0, 32'd61, 1'b1, 3'd0, 3'd6, 4'd0);
    step();
    set_disp(3'b001, 32'd40, 1'b1, 3'd0, 32'd50, 1'b1, 3'd0, 3'd1, 4'd7);
    step();
    set_disp(3'b001, 32'd100, 1'b1, 3'd0, 32'd200, 1'b1, 3'd0, 3'd2, 4'd8);
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b001 || rs_if.issueRob !== 3'd6) begin errors++; $display("FAIL busy_hold: got busy %b rob %0d expected 001/6", rs_if.ALUBusyVector, rs_if.issueRob); end
    rs_if.issueReady = 1'b1;
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd1) begin errors++; $display("FAIL busy_keep_tag: got vld %b rob %0d expected 1/1", rs_if.issueValid, rs_if.issueRob); end
    checks++; if (rs_if.issueValue1 !== 32'd40 || rs_if.issueValue2 !== 32'd50 || rs_if.issueCntrl !== 4'd7) begin errors++; $display("FAIL busy_keep_data: got %0d/%0d cntrl %0d expected 40/50/7", rs_if.issueValue1, rs_if.issueValue2, rs_if.issueCntrl); end
    step();
    checks++; if (rs_if.issueValid !== 1'b0 || rs_if.ALUBusyVector !== 3'b000) begin errors++; $display("FAIL busy_drain: got vld %b busy %b expected 0/000", rs_if.issueValid, rs_if.ALUBusyVector); end
  endtask

  task automatic test_back_to_back();
    rs_if.issueReady = 1'b1;
    set_disp(3'b001, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd1, 4'd1);
    step();
    set_disp(3'b010, 32'd2, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 3'd2, 4'd2);
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd1 || rs_if.ALUBusyVector !== 3'b010) begin errors++; $display("FAIL b2b_first: got vld %b rob %0d busy %b expected 1/1/010", rs_if.issueValid, rs_if.issueRob, rs_if.ALUBusyVector); end
    set_disp(3'b001, 32'd4, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 3'd4, 4'd4);
    step();
    clear_inputs();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd2 || rs_if.ALUBusyVector !== 3'b001) begin errors++; $display("FAIL b2b_second: got vld %b rob %0d busy %b expected 1/2/001", rs_if.issueValid, rs_if.issueRob, rs_if.ALUBusyVector); end
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd4 || rs_if.issueValue1 !== 32'd4) begin errors++; $display("FAIL b2b_third: got vld %b rob %0d v1 %0d expected 1/4/4", rs_if.issueValid, rs_if.issueRob, rs_if.issueValue1); end
    step();
    checks++; if (rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", rs_if.issueValid); end
  endtask

  task automatic test_lowest_bit();
    rs_if.issueReady = 1'b0;
    set_disp(3'b110, 32'd8, 1'b1, 3'd0, 32'd9, 1'b1, 3'd0, 3'd3, 4'd9);
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b010) begin errors++; $display("FAIL lowbit_busy: got %b expected 010", rs_if.ALUBusyVector); end
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd3 || rs_if.ALUBusyVector !== 3'b000) begin errors++; $display("FAIL lowbit_issue: got vld %b rob %0d busy %b expected 1/3/000", rs_if.issueValid, rs_if.issueRob, rs_if.ALUBusyVector); end
    rs_if.issueReady = 1'b1;
    step();
  endtask

  task automatic test_flush();
    rs_if.issueReady = 1'b0;
    set_disp(3'b001, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd1, 4'd0);
    step();
    set_disp(3'b010, 32'd2, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 3'd2, 4'd0);
    step();
    set_disp(3'b100, 32'd3, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 3'd3, 4'd0);
    step();
    set_disp(3'b001, 32'd4, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 3'd4, 4'd0);
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b111 || rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd1) begin errors++; $display("FAIL flush_setup: got busy %b vld %b rob %0d expected 111/1/1", rs_if.ALUBusyVector, rs_if.issueValid, rs_if.issueRob); end
    set_disp(3'b010, 32'd7, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 3'd7, 4'd0);
    rs_if.flush      = 1'b1;
    rs_if.issueReady = 1'b1;
    step();
    checks++; if (rs_if.ALUBusyVector !== 3'b000 || rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL flush_clear: got busy %b vld %b expected 000/0", rs_if.ALUBusyVector, rs_if.issueValid); end
    set_disp(3'b100, 32'd7, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 3'd7, 4'd0);
    rs_if.flush = 1'b1;
    step();
    clear_inputs();
    checks++; if (rs_if.ALUBusyVector !== 3'b000 || rs_if.issueValid !== 1'b0) begin errors++; $display("FAIL flush_drop_disp: got busy %b vld %b expected 000/0", rs_if.ALUBusyVector, rs_if.issueValid); end
    set_disp(3'b010, 32'd5, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 3'd5, 4'd0);
    step();
    clear_inputs();
    step();
    checks++; if (rs_if.issueValid !== 1'b1 || rs_if.issueRob !== 3'd5) begin errors++; $display("FAIL flush_recover: got vld %b rob %0d expected 1/5", rs_if.issueValid, rs_if.issueRob); end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_age_order();
    test_dispatch_capture();
    test_busy_dispatch();
    test_back_to_back();
    test_lowest_bit();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
